// File: rtl/fsm_io_pkg.sv
// Shared encodings and widths for the step-button input path.
// Pure definitions: no logic, no latency, no flow control.
// Imported by the debouncer top.
package fsm_io_pkg;

    typedef enum logic [1:0] {
        S_RELEASED   = 2'd0,
        S_PRESS_DB   = 2'd1,
        S_PRESSED    = 2'd2,
        S_RELEASE_DB = 2'd3
    } state_t;

    localparam int CNT_W   = 24;
    localparam int PRESS_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, resets to 0.
// Latency: 2 clk cycles from sampling edge to q.
// No backpressure: free-running sampler.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/step_button_debouncer.sv
// Debounces a raw push-button into single-cycle step pulses, a clean level and a press counter.
// Latency: step_pulse high the cycle after edge k+2+DEBOUNCE_COUNT (btn_in first sampled high at edge k).
// No backpressure; STEP_AUTO_REPEAT_EN adds periodic repeat pulses while held.
module step_button_debouncer
    import fsm_io_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEBOUNCE_COUNT = 24'd100_000,
    parameter logic [CNT_W-1:0] REPEAT_PERIOD  = 24'd10_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               btn_in,
    input  logic               cnt_clr,
    output logic               step_pulse,
    output logic               btn_level,
    output logic [PRESS_W-1:0] press_count
);

    localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_COUNT - CNT_W'(1);

    logic             btn_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_s)
    );

`ifdef STEP_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = REPEAT_PERIOD - CNT_W'(1);
    logic [CNT_W-1:0] rpt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_RELEASED;
            cnt        <= '0;
            step_pulse <= 1'b0;
            btn_level  <= 1'b0;
`ifdef STEP_AUTO_REPEAT_EN
            rpt        <= '0;
`endif
        end else if (!en) begin
            state      <= S_RELEASED;
            cnt        <= '0;
            step_pulse <= 1'b0;
            btn_level  <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            case (state)
                S_RELEASED: begin
                    if (btn_s) begin
                        state <= S_PRESS_DB;
                        cnt   <= '0;
                    end
                end
                S_PRESS_DB: begin
                    if (!btn_s) begin
                        state <= S_RELEASED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state      <= S_PRESSED;
                        cnt        <= '0;
                        step_pulse <= 1'b1;
                        btn_level  <= 1'b1;
`ifdef STEP_AUTO_REPEAT_EN
                        rpt        <= '0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PRESSED: begin
                    if (!btn_s) begin
                        state <= S_RELEASE_DB;
                        cnt   <= '0;
                    end
`ifdef STEP_AUTO_REPEAT_EN
                    // Repeat count only advances here; it is frozen during release debounce.
                    if (rpt == RPT_LAST) begin
                        rpt        <= '0;
                        step_pulse <= 1'b1;
                    end else begin
                        rpt <= rpt + CNT_W'(1);
                    end
`endif
                end
                S_RELEASE_DB: begin
                    if (btn_s) begin
                        state <= S_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= S_RELEASED;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Clear wins over a coincident pulse; the counter keeps its value while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_count <= '0;
        end else if (cnt_clr) begin
            press_count <= '0;
        end else if (step_pulse) begin
            press_count <= press_count + PRESS_W'(1);
        end
    end

endmodule

// File: tb/tb_step_button_debouncer.sv
// Directed plus randomized bench for step_button_debouncer with a run-length reference model.
module tb_step_button_debouncer;

    localparam int DC = 4;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    logic       btn_in = 1'b1;
    logic       cnt_clr = 1'b0;
    logic       step_pulse;
    logic       btn_level;
    logic [7:0] press_count;

    always #5 clk = ~clk;

    step_button_debouncer #(
        .DEBOUNCE_COUNT (24'd4),
        .REPEAT_PERIOD  (24'd8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .btn_in      (btn_in),
        .cnt_clr     (cnt_clr),
        .step_pulse  (step_pulse),
        .btn_level   (btn_level),
        .press_count (press_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    // Reference: debounced level changes once btn_s has differed from it for DC+1 edges in a row.
    bit m_s1 = 0, m_s2 = 0, m_level = 0, m_pulse = 0;
    int m_run = 0;
    int m_cnt = 0;
`ifdef STEP_AUTO_REPEAT_EN
    int m_rep = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit bs;
        bit pprev;
        @(posedge clk);
        if (!reset) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_run = 0; m_cnt = 0;
`ifdef STEP_AUTO_REPEAT_EN
            m_rep = 0;
`endif
        end else begin
            bs    = m_s2;
            m_s2  = m_s1;
            m_s1  = btn_in;
            pprev = m_pulse;
            m_pulse = 0;
            if (!en) begin
                m_level = 0;
                m_run   = 0;
            end else begin
`ifdef STEP_AUTO_REPEAT_EN
                if (m_level && m_run == 0) begin
                    m_rep++;
                    if (m_rep == RP) begin
                        m_rep   = 0;
                        m_pulse = 1;
                    end
                end
`endif
                if (bs != m_level) begin
                    m_run++;
                    if (m_run == DC + 1) begin
                        m_level = bs;
                        m_run   = 0;
                        if (bs) begin
                            m_pulse = 1;
`ifdef STEP_AUTO_REPEAT_EN
                            m_rep = 0;
`endif
                        end
                    end
                end else begin
                    m_run = 0;
                end
            end
            if (cnt_clr) m_cnt = 0;
            else if (pprev) m_cnt = (m_cnt + 1) % 256;
        end
        #1;
        if (step_pulse) pulses++;
        check("step_pulse", 32'(step_pulse), 32'(m_pulse));
        check("btn_level", 32'(btn_level), 32'(m_level));
        check("press_count", 32'(press_count), 32'(m_cnt));
    endtask

    task automatic hold(input bit b, input int n);
        btn_in = b;
        repeat (n) step();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pulse"}, 32'(step_pulse), 32'd0);
        check({tag, "_level"}, 32'(btn_level), 32'd0);
        check({tag, "_count"}, 32'(press_count), 32'd0);
    endtask

    initial begin
        int first;
        int p0;
        bit dropped;
        int len;

        // Reset with button already held.
        repeat (3) step();
        check_zero("reset");

        // First press after reset release: pulse 6 edges after the first sampling edge.
        reset = 1'b1;
        first = -1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (step_pulse && first < 0) first = i;
        end
        check("first_pulse_latency", 32'(first), 32'd6);
        check("first_press_count", 32'(press_count), 32'd1);
        hold(0, 10);

        // Bounce rejection.
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        p0 = pulses;
        hold(1, 1); hold(0, 1); hold(1, 1); hold(0, 1);
        hold(0, 10);
        check("bounce_pulses", 32'(pulses - p0), 32'd0);
        check("bounce_level", 32'(btn_level), 32'd0);
        check("bounce_count", 32'(press_count), 32'd0);

        // Clean press with a one-cycle release glitch.
        p0 = pulses;
        hold(1, 20);
        check("glitch_level_before", 32'(btn_level), 32'd1);
        hold(0, 1);
        btn_in = 1'b1;
        dropped = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!btn_level) dropped = 1;
        end
        check("glitch_level_held", 32'(dropped), 32'd0);
        hold(0, 10);
`ifndef STEP_AUTO_REPEAT_EN
        check("glitch_pulses", 32'(pulses - p0), 32'd1);
        check("glitch_count", 32'(press_count), 32'd1);
`endif

        // 256 presses wrap the counter.
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        repeat (256) begin
            hold(1, 8);
            hold(0, 8);
        end
        check("wrap_count", 32'(press_count), 32'd0);

        // Clear coinciding with a pulse wins.
        btn_in = 1'b1;
        first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            step();
            if (step_pulse) first = i;
        end
        check("clr_pulse_seen", 32'(first >= 0), 32'd1);
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        check("clr_priority_count", 32'(press_count), 32'd0);
        hold(1, 3);
        hold(0, 10);
        hold(1, 10);
        hold(0, 10);
        check("after_clr_count", 32'(press_count), 32'd1);

        // Enable drop while pressed, then re-enable with button still held.
        hold(1, 10);
        check("en_pressed_level", 32'(btn_level), 32'd1);
        en = 1'b0;
        step();
        check("en_drop_level", 32'(btn_level), 32'd0);
        check("en_drop_pulse", 32'(step_pulse), 32'd0);
        hold(1, 3);
        en = 1'b1;
        p0 = pulses;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (step_pulse && first < 0) first = i;
        end
        check("en_rise_latency", 32'(first), 32'(DC + 1));
        check("en_rise_pulses", 32'(pulses - p0), 32'd1);
        hold(0, 10);

        // Long hold: repeat pulses only with the auto-repeat build.
        cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        btn_in = 1'b1;
        first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            step();
            if (step_pulse) first = i;
        end
        hold(1, 40);
        hold(0, 10);
`ifdef STEP_AUTO_REPEAT_EN
        check("hold_count", 32'(press_count), 32'd6);
`else
        check("hold_count", 32'(press_count), 32'd1);
`endif

        // Async reset mid-debounce and mid-press.
        hold(1, 4);
        #2 reset = 1'b0;
        #1 check_zero("rst_mid_db");
        step();
        reset = 1'b1;
        hold(1, 12);
        check("rst_repress_level", 32'(btn_level), 32'd1);
        #2 reset = 1'b0;
        #1 check_zero("rst_mid_press");
        step();
        reset = 1'b1;
        hold(0, 10);

        // Randomized runs with occasional clears and enable drops.
        for (int r = 0; r < 300; r++) begin
            btn_in = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 10);
            repeat (len) begin
                cnt_clr = ($urandom_range(0, 29) == 0);
                en      = ($urandom_range(0, 49) != 0);
                step();
            end
        end
        en = 1'b1;
        cnt_clr = 1'b0;
        hold(0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
